// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NUM_REQ valid/ready producers,
// with a one-entry output register. Optional per-requester counters under FIFO_ARB_STATS_EN.
module fifo_wr_arbiter #(
  parameter  int DATA_WIDTH = 32,
  parameter  int NUM_REQ    = 4,
  parameter  int CNT_WIDTH  = 16,
  localparam int IDW        = $clog2(NUM_REQ)
) (
  input  logic                          i_clk,
  input  logic                          i_reset,
  input  logic [NUM_REQ-1:0]            i_req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] i_req_data,
  output logic [NUM_REQ-1:0]            o_req_ready,
  input  logic                          i_fifo_full,
  output logic                          o_fifo_wr_en,
  output logic [DATA_WIDTH-1:0]         o_fifo_data,
  output logic [IDW-1:0]                o_last_id,
  output logic [NUM_REQ*CNT_WIDTH-1:0]  o_stat_count
);

  logic                  r_out_valid;
  logic [DATA_WIDTH-1:0] r_out_data;
  logic [IDW-1:0]        r_out_id;
  logic [IDW-1:0]        r_rr_ptr;

  logic                  w_can_take;
  logic                  w_found;
  logic [IDW-1:0]        w_win;
  logic                  w_take;
  logic                  w_wr_en;
  logic [IDW-1:0]        w_next_ptr;
  logic [DATA_WIDTH-1:0] w_win_data;

  assign w_can_take = !r_out_valid || !i_fifo_full;

  // Scan from rr_ptr upward, wrapping by subtraction so non-power-of-two counts work.
  always_comb begin
    int idx;
    idx     = 0;
    w_found = 1'b0;
    w_win   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(r_rr_ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!w_found && i_req_valid[idx]) begin
        w_found = 1'b1;
        w_win   = IDW'(idx);
      end
    end
  end

  assign w_take      = w_found && w_can_take && !i_reset;
  assign o_req_ready = w_take ? (NUM_REQ'(1) << w_win) : '0;
  assign w_next_ptr  = (int'(w_win) == NUM_REQ - 1) ? '0 : w_win + 1'b1;
  assign w_win_data  = i_req_data[int'(w_win)*DATA_WIDTH +: DATA_WIDTH];

  // Reset gates the write so a held word is discarded rather than leaking out.
  assign w_wr_en      = r_out_valid && !i_fifo_full && !i_reset;
  assign o_fifo_wr_en = w_wr_en;
  assign o_fifo_data  = r_out_data;
  assign o_last_id    = r_out_id;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_id    <= '0;
      r_rr_ptr    <= '0;
    end else begin
      if (w_take) begin
        r_out_valid <= 1'b1;
        r_out_data  <= w_win_data;
        r_out_id    <= w_win;
        r_rr_ptr    <= w_next_ptr;
      end else if (w_wr_en) begin
        r_out_valid <= 1'b0;
      end
    end
  end

`ifdef FIFO_ARB_STATS_EN
  for (genvar g = 0; g < NUM_REQ; g++) begin : g_stat
    logic [CNT_WIDTH-1:0] r_cnt;
    always_ff @(posedge i_clk) begin
      if (i_reset)
        r_cnt <= '0;
      else if (w_take && (w_win == IDW'(g)) && (r_cnt != '1))
        r_cnt <= r_cnt + 1'b1;
    end
    assign o_stat_count[g*CNT_WIDTH +: CNT_WIDTH] = r_cnt;
  end
`else
  assign o_stat_count = '0;
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: reset, rotation, skip, backpressure,
// mid-stream reset and (when FIFO_ARB_STATS_EN is defined) saturating counters.
module tb_fifo_wr_arbiter;
  localparam int DW = 32;
  localparam int NR = 4;
  localparam int CW = 4;

  logic              clk;
  logic              reset;
  logic [NR-1:0]     req_valid;
  logic [NR*DW-1:0]  req_data;
  logic [NR-1:0]     req_ready;
  logic              fifo_full;
  logic              fifo_wr_en;
  logic [DW-1:0]     fifo_data;
  logic [1:0]        last_id;
  logic [NR*CW-1:0]  stat_count;

  int errors = 0;
  int checks = 0;

  fifo_wr_arbiter #(.DATA_WIDTH(DW), .NUM_REQ(NR), .CNT_WIDTH(CW)) dut (
    .i_clk(clk), .i_reset(reset), .i_req_valid(req_valid), .i_req_data(req_data),
    .o_req_ready(req_ready), .i_fifo_full(fifo_full), .o_fifo_wr_en(fifo_wr_en),
    .o_fifo_data(fifo_data), .o_last_id(last_id), .o_stat_count(stat_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [1:0]  skip_ord [4];
    logic [15:0] stat_exp;
    skip_ord = '{2'd3, 2'd1, 2'd3, 2'd1};

    reset     = 1'b1;
    fifo_full = 1'b0;
    req_valid = 4'b1111;
    for (int i = 0; i < NR; i++) req_data[i*DW +: DW] = 32'hA0 + i;

    // Reset held for two cycles with all requesters valid
    for (int c = 0; c < 2; c++) begin
      tick(); settle();
      check("rst_ready", 32'(req_ready), 32'h0);
      check("rst_wr_en", 32'(fifo_wr_en), 32'h0);
      check("rst_data",  fifo_data, 32'h0);
      check("rst_id",    32'(last_id), 32'h0);
    end
    check("rst_stats", 32'(stat_count), 32'h0);

    // Rotation
    tick();
    reset = 1'b0;
    settle();
    check("first_grant", 32'(req_ready), 32'b0001);
    for (int i = 0; i < 8; i++) begin
      tick(); settle();
      check("rot_wr_en", 32'(fifo_wr_en), 32'h1);
      check("rot_data",  fifo_data, 32'hA0 + (i % 4));
      check("rot_id",    32'(last_id), 32'(i % 4));
      check("rot_ready", 32'(req_ready), 32'(1 << ((i + 1) % 4)));
    end
    req_valid = 4'b0000;
    tick(); settle();
    check("rot_drained", 32'(fifo_wr_en), 32'h0);

    // Skip: move rr_ptr to 2 via a grant to requester 1, then only 1 and 3 valid
    req_valid = 4'b0010;
    tick();
    req_valid = 4'b1010;
    settle();
    for (int g = 0; g < 4; g++) begin
      check("skip_ready", 32'(req_ready), 32'(1 << skip_ord[g]));
      tick(); settle();
      check("skip_id",   32'(last_id), 32'(skip_ord[g]));
      check("skip_data", fifo_data, 32'hA0 + 32'(skip_ord[g]));
    end
    req_valid = 4'b0000;
    tick(); settle();

    // Backpressure: 0x55 from requester 2 held while full
    fifo_full = 1'b1;
    req_data[2*DW +: DW] = 32'h55;
    req_valid = 4'b0100;
    settle();
    check("bp_accept", 32'(req_ready), 32'b0100);
    tick();
    req_valid = 4'b0001;
    for (int c = 0; c < 5; c++) begin
      settle();
      check("bp_wr_en", 32'(fifo_wr_en), 32'h0);
      check("bp_data",  fifo_data, 32'h55);
      check("bp_ready", 32'(req_ready), 32'h0);
      if (c < 4) tick();
    end
    tick();
    fifo_full = 1'b0;
    req_valid = 4'b0000;
    settle();
    check("bp_release_wr", 32'(fifo_wr_en), 32'h1);
    check("bp_release_data", fifo_data, 32'h55);
    check("bp_release_id", 32'(last_id), 32'h2);
    tick(); settle();
    check("bp_drained", 32'(fifo_wr_en), 32'h0);

    // Reset mid-stream: 0x77 captured under full, then reset discards it
    fifo_full = 1'b1;
    req_data[0 +: DW] = 32'h77;
    req_valid = 4'b0001;
    settle();
    check("mid_accept", 32'(req_ready), 32'b0001);
    tick();
    req_valid = 4'b0000;
    settle();
    check("mid_held", fifo_data, 32'h77);
    reset = 1'b1;
    settle();
    check("mid_no_wr", 32'(fifo_wr_en), 32'h0);
    tick();
    reset = 1'b0;
    fifo_full = 1'b0;
    settle();
    check("mid_wr_en", 32'(fifo_wr_en), 32'h0);
    check("mid_data",  fifo_data, 32'h0);
    check("mid_stats", 32'(stat_count), 32'h0);
    req_valid = 4'b1111;
    settle();
    check("mid_rr_zero", 32'(req_ready), 32'b0001);
    req_valid = 4'b0000;
    tick(); settle();

    // Stats: 20 transfers from requester 1
    req_data[1*DW +: DW] = 32'h11;
    req_valid = 4'b0010;
    for (int t = 0; t < 20; t++) begin
      tick();
      if (t == 4) begin
        settle();
`ifdef FIFO_ARB_STATS_EN
        stat_exp = 16'h0050;
`else
        stat_exp = 16'h0000;
`endif
        check("stat_five", 32'(stat_count), 32'(stat_exp));
      end
    end
    req_valid = 4'b0000;
    tick(); settle();
`ifdef FIFO_ARB_STATS_EN
    stat_exp = 16'h00F0;
`else
    stat_exp = 16'h0000;
`endif
    check("stat_sat", 32'(stat_count), 32'(stat_exp));
    check("stat_idle", 32'(fifo_wr_en), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
